// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: opcodes, flag bit positions, the buffered entry and buffer occupancy states.
package ex_pkg;

    localparam int EX_DATA_W = 16;
    localparam int EX_REG_W  = 4;
    localparam int EX_OP_W   = 4;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_RED = 4'h3;

    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    typedef struct packed {
        logic [EX_OP_W-1:0]   opcode;
        logic [EX_DATA_W-1:0] result;
        logic [EX_REG_W-1:0]  dst;
        logic                 regwrite;
    } ex_entry_t;

    // Encoding doubles as the valid bits: bit0 = main_valid, bit1 = skid_valid.
    typedef enum logic [1:0] {
        BUF_E = 2'b00,
        BUF_M = 2'b01,
        BUF_F = 2'b11
    } buf_state_t;

endpackage

// File: rtl/flag_unit.sv
// Architectural {Z,V,N} flag register with next-flag decode; loads only on accepted EX results.
// RED_FLAGS_EN: when defined, RED results also update Z and N.
module flag_unit
    import ex_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] result,
    input  logic              ovf,
    output logic [2:0]        flags
);

    logic [2:0] flags_nxt;
    logic       zero;

    always_comb begin
        flags_nxt = flags;
        zero      = (result == '0);
        case (opcode)
            OP_ADD, OP_SUB: begin
                flags_nxt[FLG_Z] = zero;
                flags_nxt[FLG_V] = ovf;
                flags_nxt[FLG_N] = result[DATA_W-1];
            end
            OP_XOR: begin
                flags_nxt[FLG_Z] = zero;
            end
            OP_RED: begin
`ifdef RED_FLAGS_EN
                flags_nxt[FLG_Z] = zero;
                flags_nxt[FLG_N] = result[DATA_W-1];
`endif
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= 3'b000;
        end else if (en) begin
            flags <= flags_nxt;
        end
    end

endmodule

// File: rtl/ex_result_skid.sv
// EX-stage output: 2-entry skid buffer (main = head, skid = overflow) toward MEM, plus the flag register.
// RED_FLAGS_EN: selects whether RED results update flags (buffering unaffected).
module ex_result_skid
    import ex_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int REG_W  = EX_REG_W,
    parameter int OP_W   = EX_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_ovf,
    input  logic [REG_W-1:0]  in_dst,
    input  logic              in_regwrite,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_opcode,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_dst,
    output logic              out_regwrite,
    output logic [2:0]        flags
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready depends only on registered state, never on out_ready.
    buf_state_t state, state_nxt;
    ex_entry_t  main_q, skid_q, in_entry;
    logic       accept, pop;
    logic       load_main, load_skid, skid_to_main;

    assign out_valid = state[0];
    assign in_ready  = ~state[1];

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    assign in_entry = '{opcode: in_opcode, result: in_result,
                        dst: in_dst, regwrite: in_regwrite};

    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_nxt = BUF_E;
        end else begin
            case (state)
                BUF_E: begin
                    if (accept) begin
                        state_nxt = BUF_M;
                        load_main = 1'b1;
                    end
                end
                BUF_M: begin
                    case ({pop, accept})
                        2'b10: state_nxt = BUF_E;
                        2'b11: load_main = 1'b1;
                        2'b01: begin
                            state_nxt = BUF_F;
                            load_skid = 1'b1;
                        end
                        default: state_nxt = BUF_M;
                    endcase
                end
                BUF_F: begin
                    if (pop) begin
                        state_nxt    = BUF_M;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_nxt = BUF_E;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= BUF_E;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                main_q <= in_entry;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign out_opcode   = main_q.opcode;
    assign out_result   = main_q.result;
    assign out_dst      = main_q.dst;
    assign out_regwrite = main_q.regwrite;

    flag_unit #(
        .DATA_W(DATA_W),
        .OP_W  (OP_W)
    ) u_flag_unit (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .opcode(in_opcode),
        .result(in_result),
        .ovf   (in_ovf),
        .flags (flags)
    );

endmodule

// File: doc/ex_result_skid.md
Name: ex_result_skid

Overview:
- Execute-stage output stage. Sits directly downstream of the reduction unit and its sibling ALU datapaths.
- Captures the selected 16-bit EX result with its destination tag into a 2-entry skid buffer.
- Presents the buffered result to the MEM stage with a valid/ready handshake.
- Owns the architectural flag register {Z,V,N} read by branch resolution.

Parameters:
- DATA_W, 16, result datapath width.
- REG_W, 4, destination register index width.
- OP_W, 4, opcode width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  squash all buffered entries and the current input this cycle.
- in_valid  input  1  EX result valid.
- in_ready  output  1  buffer can accept. Registered; equals !skid_valid.
- in_opcode  input  OP_W  opcode of the EX instruction.
- in_result  input  DATA_W  selected result (ALU, RED, shifter, etc.).
- in_ovf  input  1  signed-overflow indication from ADD/SUB.
- in_dst  input  REG_W  destination register.
- in_regwrite  input  1  writes register file.
- out_valid  output  1  head entry valid.
- out_ready  input  1  MEM stage accepts head.
- out_opcode  output  OP_W  head opcode.
- out_result  output  DATA_W  head result.
- out_dst  output  REG_W  head destination.
- out_regwrite  output  1  head regwrite.
- flags  output  3  {Z,V,N}, registered.

Behaviour:
- Reset (rst_n=0 at posedge):
  - main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
  - flags=3'b000.
  - Payload registers are cleared to 0.
  - Reset asserted mid-transfer drops all entries; there is no partial-state retention.
- Accept: accept = in_valid & in_ready & !flush.
- Pop: pop = out_valid & out_ready.
- Head and skid storage:
  - Head is main. Skid holds an overflow entry captured while the head is stalled.
  - Latency: an accepted entry with the buffer empty (or main popping with no skid) appears on out_* the next cycle.
- Transitions per cycle (E=empty, M=main only, F=main+skid):
  - E: accept -> M (load main).
  - M, pop & !accept -> E.
  - M, pop & accept -> M (main reloaded from input).
  - M, !pop & accept -> F (load skid).
  - M, !pop & !accept -> M (hold).
  - F: in_ready=0, so no accept is possible.
  - F, pop -> M (skid moves into main; skid_valid cleared).
  - F, !pop -> F (hold).
- Output stability: out_* stays stable while out_valid=1 and out_ready=0.
- flush:
  - Next state is E. All valid bits are cleared.
  - flush has priority over accept and pop.
  - Flags are not updated by the squashed input.
- Flag update:
  - Occurs on accept only, at the same clock edge the entry is captured.
  - Independent of downstream stall, so a branch in ID sees flags one cycle after EX.
  - Opcode 0000 ADD / 0001 SUB: N=in_result[15], Z=(in_result==0), V=in_ovf.
  - Opcode 0010 XOR: Z=(in_result==0); N and V hold.
  - All other opcodes: flags hold (RED handled under the optional feature).
- Width rules:
  - Z is computed over the full DATA_W.
  - No arithmetic is performed here; the result passes through unmodified.

Optional Feature:
- Macro: RED_FLAGS_EN.
- Defined: opcode 0011 RED updates Z=(in_result==0) and N=in_result[15]. V holds.
- Undefined: RED leaves all flags unchanged.
- Buffering is identical in both builds.

Decomposition:
- Shared package ex_pkg:
  - Opcode localparams OP_ADD=4'h0, OP_SUB=4'h1, OP_XOR=4'h2, OP_RED=4'h3.
  - Flag bit indices FLG_Z=2, FLG_V=1, FLG_N=0.
  - Packed ex_entry_t {opcode, result, dst, regwrite}.
- Natural sub-module flag_unit:
  - Combinational next-flag decode from opcode, result and ovf, plus the flag register with accept enable and rst_n.
  - The skid-buffer control and payload registers stay in ex_result_skid.

Test Plan:
- Reset, then single pass-through:
  - Hold rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, flags=000.
  - Accept ADD result=0x0000, ovf=0, with out_ready=1 -> next cycle out_valid=1, out_result=0x0000, flags=100.
- Stall fill:
  - out_ready=0, accept SUB 0x8000 ovf=1, then XOR 0x1234 -> buffer reaches F, in_ready=0.
  - flags=011 after SUB, then 011 after XOR (Z=0; N and V hold).
  - Then out_ready=1 -> outputs 0x8000 then 0x1234 in order, with no loss or duplication.
- Simultaneous pop and accept in M:
  - Head ADD 0x0001, in ADD 0x0002, out_ready=1 -> next cycle head=0x0002, skid_valid stays 0.
- Flush with buffer F and in_valid=1 (ADD 0x0000):
  - Next cycle out_valid=0, in_ready=1, flags unchanged from the previous value.
- RED flags:
  - RED result=0xFFF6 accepted -> with RED_FLAGS_EN flags={0,V,1}; without it flags unchanged.
- Mid-operation reset:
  - rst_n=0 while in state F -> next cycle out_valid=0, flags=000, in_ready=1.
